// File: rtl/drop_sequencer.sv
// Drop-stage sequencer: arms on start, counts ticks, drives drop_en and reports the outcome.
// Optional DROP_SEQ_AUTOACK_EN: DONE/HOT return to IDLE after AUTOACK_CYC cycles without ack.
module drop_sequencer #(
    parameter int HOLD_CYC    = 4,
    parameter int AUTOACK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [15:0] t_lim,
    input  logic        drop_cmd,
    input  logic        abort,
    input  logic        ack,
    input  logic        drop_activated,
    output logic [15:0] t_act,
    output logic [15:0] lim_q,
    output logic        drop_en,
    output logic        ready,
    output logic        done,
    output logic        hot,
    output logic        drop_ok,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DROP  = 3'd2,
        HOT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Hold and auto-ack counters share one width wide enough for either delay.
    localparam int MAX_CYC = (HOLD_CYC > AUTOACK_CYC) ? HOLD_CYC : AUTOACK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt;
    logic             overtime;
    logic             hold_last;
    logic             aa_fire;

    assign overtime  = (t_act > lim_q);
    assign hold_last = (hold_cnt == HOLD_LAST);

`ifdef DROP_SEQ_AUTOACK_EN
    localparam logic [CNT_W-1:0] AA_LAST = CNT_W'(AUTOACK_CYC - 1);
    logic [CNT_W-1:0] aa_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            aa_cnt <= '0;
        end else if (state_q == DONE || state_q == HOT) begin
            aa_cnt <= aa_cnt + CNT_W'(1);
        end else begin
            aa_cnt <= '0;
        end
    end

    assign aa_fire = (aa_cnt == AA_LAST);
`else
    assign aa_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = COUNT;
            end
            COUNT: begin
                if (abort)         state_d = IDLE;
                else if (overtime) state_d = HOT;
                else if (drop_cmd) state_d = DROP;
            end
            DROP: begin
                if (abort)          state_d = IDLE;
                else if (hold_last) state_d = DONE;
            end
            HOT, DONE: begin
                if (abort || ack || aa_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Elapsed time, latched limit, hold counter and drop result.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_act    <= 16'h0000;
            lim_q    <= 16'hFFFF;
            drop_ok  <= 1'b0;
            hold_cnt <= '0;
        end else if (abort && state_q != IDLE) begin
            t_act <= 16'h0000;
            lim_q <= 16'hFFFF;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lim_q <= t_lim;
                        t_act <= 16'h0000;
                    end
                end
                COUNT: begin
                    if (tick && t_act != 16'hFFFF) t_act <= t_act + 16'd1;
                    if (overtime)      drop_ok  <= 1'b0;
                    else if (drop_cmd) hold_cnt <= '0;
                end
                DROP: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (hold_last) drop_ok <= drop_activated;
                end
                default: ;
            endcase
        end
    end

    assign drop_en = (state_q == DROP) || (state_q == HOT);
    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign hot     = (state_q == HOT);
    assign state   = state_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer; expectations hand-computed. Honours DROP_SEQ_AUTOACK_EN.
module tb_drop_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [15:0] t_lim = 16'd0;
    logic        drop_cmd = 1'b0;
    logic        abort = 1'b0;
    logic        ack = 1'b0;
    logic        drop_activated = 1'b0;
    logic [15:0] t_act;
    logic [15:0] lim_q;
    logic        drop_en;
    logic        ready;
    logic        done;
    logic        hot;
    logic        drop_ok;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    drop_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .start          (start),
        .t_lim          (t_lim),
        .drop_cmd       (drop_cmd),
        .abort          (abort),
        .ack            (ack),
        .drop_activated (drop_activated),
        .t_act          (t_act),
        .lim_q          (lim_q),
        .drop_en        (drop_en),
        .ready          (ready),
        .done           (done),
        .hot            (hot),
        .drop_ok        (drop_ok),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are settled 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;

        // Reset
        repeat (2) cyc();
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_t_act", t_act, 0);
        check("rst_lim_q", lim_q, 16'hFFFF);
        check("rst_drop_en", drop_en, 0);
        check("rst_ready", ready, 1);
        check("rst_drop_ok", drop_ok, 0);

        // Normal drop
        t_lim = 16'd10; start = 1'b1; cyc(); start = 1'b0;
        check("nd_state_count", state, 1);
        check("nd_ready_low", ready, 0);
        check("nd_lim_q", lim_q, 10);
        tick = 1'b1; repeat (5) cyc(); tick = 1'b0;
        check("nd_t_act5", t_act, 5);
        drop_cmd = 1'b1; drop_activated = 1'b1; cyc(); drop_cmd = 1'b0;
        check("nd_state_drop", state, 2);
        hi = 0;
        for (int i = 0; i < 10 && drop_en; i++) begin
            hi++;
            cyc();
        end
        check("nd_drop_en_cycles", hi, 4);
        check("nd_done", done, 1);
        check("nd_drop_ok", drop_ok, 1);
        check("nd_t_act_frozen", t_act, 5);
        drop_activated = 1'b0;
        ack = 1'b1; cyc(); ack = 1'b0;
        check("nd_ack_idle", state, 0);
        check("nd_ack_ready", ready, 1);

        // Abort during DROP hold cycle 2
        t_lim = 16'd100; start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; repeat (2) cyc(); tick = 1'b0;
        drop_cmd = 1'b1; cyc(); drop_cmd = 1'b0;
        tick = 1'b1; cyc();
        check("ab_t_act_frozen", t_act, 2);
        check("ab_in_drop", state, 2);
        abort = 1'b1; cyc(); abort = 1'b0; tick = 1'b0;
        check("ab_state", state, 0);
        check("ab_drop_en", drop_en, 0);
        check("ab_t_act", t_act, 0);
        check("ab_lim_q", lim_q, 16'hFFFF);
        check("ab_drop_ok_kept", drop_ok, 1);

        // Overtime
        t_lim = 16'd3; start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; repeat (4) cyc(); tick = 1'b0;
        check("ot_t_act4", t_act, 4);
        check("ot_still_count", state, 1);
        cyc();
        check("ot_state_hot", state, 3);
        check("ot_hot", hot, 1);
        check("ot_drop_en", drop_en, 1);
        check("ot_drop_ok_clr", drop_ok, 0);
        drop_cmd = 1'b1; tick = 1'b1; cyc(); drop_cmd = 1'b0; tick = 1'b0;
        check("ot_cmd_ignored", state, 3);
        check("ot_t_act_frozen", t_act, 4);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("ot_ack_idle", state, 0);
        check("ot_idle_t_act_hold", t_act, 4);

        // Overtime and drop_cmd together; ack ignored in COUNT
        t_lim = 16'd2; start = 1'b1; cyc(); start = 1'b0;
        ack = 1'b1; tick = 1'b1; repeat (3) cyc(); tick = 1'b0; ack = 1'b0;
        check("sim_ack_ignored", state, 1);
        check("sim_t_act3", t_act, 3);
        drop_cmd = 1'b1; cyc(); drop_cmd = 1'b0;
        check("sim_hot_wins", state, 3);
        ack = 1'b1; cyc(); ack = 1'b0;

        // drop_activated sampled only at the final hold edge
        t_lim = 16'd20; start = 1'b1; cyc(); start = 1'b0;
        drop_cmd = 1'b1; cyc(); drop_cmd = 1'b0;
        repeat (3) cyc();
        check("samp_still_drop", state, 2);
        drop_activated = 1'b1; cyc(); drop_activated = 1'b0;
        check("samp_done", done, 1);
        check("samp_drop_ok", drop_ok, 1);
        ack = 1'b1; cyc(); ack = 1'b0;

        // Saturation, start ignored in COUNT
        t_lim = 16'hFFFF; start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1;
        repeat (100) cyc();
        t_lim = 16'd5; start = 1'b1; cyc(); start = 1'b0;
        check("sat_start_ignored_lim", lim_q, 16'hFFFF);
        check("sat_start_ignored_t", t_act, 101);
        repeat (69899) cyc();
        tick = 1'b0;
        check("sat_t_act", t_act, 16'hFFFF);
        check("sat_state_count", state, 1);
        abort = 1'b1; cyc(); abort = 1'b0;
        check("sat_abort_idle", state, 0);
        check("sat_abort_t_act", t_act, 0);

        // Auto-ack
        t_lim = 16'd50; start = 1'b1; cyc(); start = 1'b0;
        drop_cmd = 1'b1; cyc(); drop_cmd = 1'b0;
        repeat (4) cyc();
        check("aa_done_entry", state, 4);
`ifdef DROP_SEQ_AUTOACK_EN
        repeat (15) cyc();
        check("aa_still_done", state, 4);
        cyc();
        check("aa_auto_idle", state, 0);
`else
        repeat (100) cyc();
        check("aa_held_done", state, 4);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("aa_ack_idle", state, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
